// File: rtl/ecg_seq_pkg.sv
// Shared state encoding, status codes and data width for the ECG feature sequencer.
package ecg_seq_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StWaitQrs,
        StWaitPt,
        StSettle,
        StPresent
    } seq_state_e;

    typedef logic [1:0] status_t;

    localparam status_t STAT_OK     = 2'b00;
    localparam status_t STAT_QRS_TO = 2'b01;
    localparam status_t STAT_PT_TO  = 2'b10;

endpackage

// File: rtl/ecg_seq_watchdog.sv
// Cycle-count watchdog for the sequencer wait states; expired flags the limit-th counted cycle.
module ecg_seq_watchdog
    import ecg_seq_pkg::*;
(
    input  logic  clk,
    input  logic  nReset,
    input  logic  clear,
    input  logic  enable,
    input  data_t limit,
    output logic  expired
);

    data_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + data_t'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q is zero on the first cycle in a wait state, so this fires on cycle number 'limit'.
    assign expired = enable && (cnt_q == (limit - data_t'(1)));

endmodule

// File: rtl/ecg_feature_sequencer.sv
// Window sequencer for the ECG DWT/feature datapath: clear, stream samples, wait, present results.
// Optional watchdog on the wait states is built when ECG_SEQ_TIMEOUT_EN is defined.
module ecg_feature_sequencer
    import ecg_seq_pkg::*;
#(
    parameter int unsigned CLR_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [DATA_W-1:0] win_len,
    output logic              busy,
    output logic              rd_en,
    output logic [DATA_W-1:0] rd_addr,
    output logic              core_nreset,
    output logic              core_run,
    input  logic              qrs_valid,
    input  logic              p_done,
    input  logic              p2_need,
    input  logic              p2_done,
    input  logic              t_done,
    input  logic [DATA_W-1:0] p_begin_in,
    input  logic [DATA_W-1:0] p_end_in,
    input  logic [DATA_W-1:0] t_begin_in,
    input  logic [DATA_W-1:0] t_end_in,
    output logic [DATA_W-1:0] feat_p_begin,
    output logic [DATA_W-1:0] feat_p_end,
    output logic [DATA_W-1:0] feat_t_begin,
    output logic [DATA_W-1:0] feat_t_end,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [1:0]        status
);

    localparam data_t ClrLast    = data_t'(CLR_CYC - 1);
    localparam data_t TimeoutLim = data_t'(TIMEOUT_CYC);

    seq_state_e state_q, state_d;
    data_t      len_q, len_d;
    data_t      addr_q, addr_d;
    data_t      clr_cnt_q, clr_cnt_d;
    logic       nres_q, nres_d;
    data_t      p_begin_q, p_begin_d;
    data_t      p_end_q, p_end_d;
    data_t      t_begin_q, t_begin_d;
    data_t      t_end_q, t_end_d;
    status_t    status_q, status_d;
    logic       pt_done;
    logic       wd_expired;

    assign pt_done = p_done && t_done && (!p2_need || p2_done);

`ifdef ECG_SEQ_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // Restart the count on every entry into a wait state, including WAIT_QRS -> WAIT_PT.
    assign wd_clear = ((state_d == StWaitQrs) && (state_q != StWaitQrs)) ||
                      ((state_d == StWaitPt) && (state_q != StWaitPt));
    assign wd_enable = (state_q == StWaitQrs) || (state_q == StWaitPt);

    ecg_seq_watchdog u_watchdog (
        .clk     (clk),
        .nReset  (nReset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (TimeoutLim),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = ^TimeoutLim;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        clr_cnt_d = clr_cnt_q;
        p_begin_d = p_begin_q;
        p_end_d   = p_end_q;
        t_begin_d = t_begin_q;
        t_end_d   = t_end_q;
        status_d  = status_q;

        unique case (state_q)
            StIdle: begin
                if (start && (win_len != '0)) begin
                    len_d     = win_len;
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                if (clr_cnt_q == ClrLast) begin
                    addr_d  = '0;
                    state_d = StStream;
                end else begin
                    clr_cnt_d = clr_cnt_q + data_t'(1);
                end
            end
            StStream: begin
                if (addr_q == (len_q - data_t'(1))) begin
                    state_d = StWaitQrs;
                end else begin
                    addr_d = addr_q + data_t'(1);
                end
            end
            StWaitQrs: begin
                if (qrs_valid) begin
                    state_d = StWaitPt;
                end else if (wd_expired) begin
                    p_begin_d = '0;
                    p_end_d   = '0;
                    t_begin_d = '0;
                    t_end_d   = '0;
                    status_d  = STAT_QRS_TO;
                    state_d   = StPresent;
                end
            end
            StWaitPt: begin
                if (pt_done) begin
                    state_d = StSettle;
                end else if (wd_expired) begin
                    p_begin_d = '0;
                    p_end_d   = '0;
                    t_begin_d = '0;
                    t_end_d   = '0;
                    status_d  = STAT_PT_TO;
                    state_d   = StPresent;
                end
            end
            StSettle: begin
                p_begin_d = p_begin_in;
                p_end_d   = p_end_in;
                t_begin_d = t_begin_in;
                t_end_d   = t_end_in;
                status_d  = STAT_OK;
                state_d   = StPresent;
            end
            StPresent: begin
                if (feat_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered from the next state so the soft reset lines up exactly with CLEAR.
        nres_d = (state_d != StClear);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= StIdle;
            len_q     <= '0;
            addr_q    <= '0;
            clr_cnt_q <= '0;
            nres_q    <= 1'b0;
            p_begin_q <= '0;
            p_end_q   <= '0;
            t_begin_q <= '0;
            t_end_q   <= '0;
            status_q  <= STAT_OK;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            clr_cnt_q <= clr_cnt_d;
            nres_q    <= nres_d;
            p_begin_q <= p_begin_d;
            p_end_q   <= p_end_d;
            t_begin_q <= t_begin_d;
            t_end_q   <= t_end_d;
            status_q  <= status_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign rd_en        = (state_q == StStream);
    assign rd_addr      = addr_q;
    assign core_nreset  = nres_q;
    assign core_run     = (state_q == StStream) || (state_q == StWaitQrs) ||
                          (state_q == StWaitPt) || (state_q == StSettle);
    assign feat_valid   = (state_q == StPresent);
    assign feat_p_begin = p_begin_q;
    assign feat_p_end   = p_end_q;
    assign feat_t_begin = t_begin_q;
    assign feat_t_end   = t_end_q;
    assign status       = status_q;

endmodule
